pipelined_cla_adder: RTL

//  Parametrised, pipelined carry-lookahead adder; successor to the fixed 4-bit CLA.

---
 rtl/cla_pkg.sv | 18 +
 rtl/cla_group.sv | 50 +++++
 rtl/pipelined_cla_adder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared sizing helpers for the pipelined carry-lookahead adder.
// Combinational only; no handshake.
// Group counts derive from WIDTH/BLOCK/STAGES at elaboration.
package cla_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_BLOCK  = 4;
  localparam int DEF_STAGES = 2;

  function automatic int num_groups(input int width, input int block);
    return width / block;
  endfunction

  function automatic int groups_per_stage(input int width, input int block, input int stages);
    return width / (block * stages);
  endfunction

endpackage

// File: rtl/cla_group.sv
// BLOCK-bit lookahead group: sum bits plus group propagate/generate.
// Purely combinational, zero latency.
// No handshake; the enclosing stage registers own flow control.
module cla_group #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             gp,
  output logic             gg
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] c;
  logic             acc;
  logic             pp;

  assign p = a ^ b;
  assign g = a & b;
  assign s = p ^ c;
  assign gp = &p;

  // Every bit carry is a flat sum-of-products of g/p and ci, not a ripple.
  always_comb begin
    c   = '0;
    gg  = 1'b0;
    acc = 1'b0;
    pp  = 1'b1;
    for (int j = 0; j < BLOCK; j++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int i = j - 1; i >= 0; i--) begin
        acc = acc | (g[i] & pp);
        pp  = pp & p[i];
      end
      c[j] = acc | (pp & ci);
    end
    acc = 1'b0;
    pp  = 1'b1;
    for (int i = BLOCK - 1; i >= 0; i--) begin
      acc = acc | (g[i] & pp);
      pp  = pp & p[i];
    end
    gg = acc;
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA: sum = a + b + cin, BLOCK-bit groups resolved over STAGES register stages.
// Latency STAGES cycles; one result per cycle; global stall when out_valid && !out_ready.
// Optional CLA_OVERFLOW_EN adds a registered signed-overflow output ovf.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int BLOCK  = DEF_BLOCK,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG = num_groups(WIDTH, BLOCK);
  localparam int G  = groups_per_stage(WIDTH, BLOCK, STAGES);

  // Operands ride along until their groups are consumed; s fills in stage by stage.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
  } payload_t;

  payload_t          st_d [STAGES];
  payload_t          st_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic              advance;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign sum       = st_q[STAGES-1].s;
  assign cout      = st_q[STAGES-1].c;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    payload_t         sin;
    payload_t         sout;
    logic [G-1:0]     gp;
    logic [G-1:0]     gg;
    logic [G:0]       gc;
    logic [BLOCK-1:0] gs [G];
    logic             acc;
    logic             pp;

    if (k == 0) begin : g_first
      assign sin = '{a: a, b: b, s: '0, c: cin};
    end else begin : g_next
      assign sin = st_q[k-1];
    end

    for (genvar j = 0; j < G; j++) begin : g_grp
      cla_group #(.BLOCK(BLOCK)) u_grp (
        .a  (sin.a[(k*G+j)*BLOCK +: BLOCK]),
        .b  (sin.b[(k*G+j)*BLOCK +: BLOCK]),
        .ci (gc[j]),
        .s  (gs[j]),
        .gp (gp[j]),
        .gg (gg[j])
      );
    end

    // Second-level lookahead across this stage's groups from the registered stage carry.
    always_comb begin
      gc  = '0;
      acc = 1'b0;
      pp  = 1'b1;
      for (int j = 0; j <= G; j++) begin
        acc = 1'b0;
        pp  = 1'b1;
        for (int i = j - 1; i >= 0; i--) begin
          acc = acc | (gg[i] & pp);
          pp  = pp & gp[i];
        end
        gc[j] = acc | (pp & sin.c);
      end
    end

    always_comb begin
      sout = sin;
      for (int j = 0; j < G; j++) begin
        sout.s[(k*G+j)*BLOCK +: BLOCK] = gs[j];
      end
      sout.c = gc[G];
    end

    assign st_d[k] = sout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

`ifdef CLA_OVERFLOW_EN
  logic msb_carry;
  logic ovf_q;

  // Carry into the MSB recovered from the final-stage sum bit and its operands.
  assign msb_carry = st_d[STAGES-1].a[WIDTH-1] ^ st_d[STAGES-1].b[WIDTH-1]
                   ^ st_d[STAGES-1].s[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= msb_carry ^ st_d[STAGES-1].c;
    end
  end

  assign ovf = ovf_q;
`endif

  logic unused_ok;
  assign unused_ok = ^{NG};

endmodule
